// File: rtl/muu_sequencer.sv
// rtl/muu_sequencer.sv - HI/LO owner sequencing multiply-class ops and a 32-step restoring divide
//
// Optional feature macro: MUU_ACCUM_EN (MADD/MSUBU accumulate into HI:LO; undefined -> ops 2/3 illegal)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   start      request valid, held by EX until accepted (start & ready)
//   op         0 MUL, 1 MULT, 2 MADD, 3 MSUBU, 4 DIV, 5 MFHI, 6 MFLO
//   rs, rt     operands, sampled only in the accept cycle
//   ready      idle, or in the completion cycle of a multi-cycle op
//   busy       ~ready
//   done       one-cycle completion pulse
//   out        result for MUL/MFHI/MFLO, held until the next out_valid
//   out_valid  one-cycle pulse with done for MUL/MFHI/MFLO
//   div_zero   one-cycle pulse with done for DIV by zero
//   illegal    one-cycle pulse with done for an unsupported op
//   hi_o, lo_o current HI/LO
module muu_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int OP_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs,
  input  logic [31:0]     rt,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [31:0]     out,
  output logic            out_valid,
  output logic            div_zero,
  output logic            illegal,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o
);

  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
`ifdef MUU_ACCUM_EN
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(3);
`endif
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);

  typedef enum logic [1:0] {IDLE, MULW, DIVI, DIVF} state_t;

  state_t          state, state_nxt, accept_tgt;
  logic [4:0]      cnt;
  logic [OP_W-1:0] op_q;
  logic [31:0]     a_q, b_q;
  logic [31:0]     rem_q, quo_q, div_q;
  logic            rs_neg_q, rt_neg_q;
  logic [31:0]     hi_q, lo_q, hi_nxt, lo_nxt;
  logic [31:0]     out_q;
  logic            done_q, out_valid_q, div_zero_q, illegal_q;

  logic            accept, is_mulc, is_div, is_mf;
  logic            mul_fin, div_fin, mul_out_live;
  logic [63:0]     prod_s;
  logic [32:0]     r2, diff;
  logic [31:0]     rem_step, quo_step;

  // Request decode
  always_comb begin
    is_mulc = (op == OP_MUL) || (op == OP_MULT)
`ifdef MUU_ACCUM_EN
              || (op == OP_MADD) || (op == OP_MSUBU)
`endif
              ;
    is_div  = (op == OP_DIV);
    is_mf   = (op == OP_MFHI) || (op == OP_MFLO);
    accept  = start && ready;
    if (is_mulc)
      accept_tgt = MULW;
    else if (is_div && (rt != 32'd0))
      accept_tgt = DIVI;
    else
      accept_tgt = IDLE;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state. The completion cycle also accepts, so a follow-on
  // request can issue back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = accept_tgt;
      MULW: if (cnt == 5'd0) state_nxt = accept ? accept_tgt : IDLE;
      DIVI: if (cnt == 5'd0) state_nxt = DIVF;
      DIVF: state_nxt = accept ? accept_tgt : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Multi-cycle ops complete combinationally in their last
  // cycle and commit HI/LO on the edge that ends it.
  always_comb begin
    mul_fin = (state == MULW) && (cnt == 5'd0);
    div_fin = (state == DIVF);
    ready   = (state == IDLE) || mul_fin || div_fin;
    busy    = ~ready;
  end

  // Multiply from registered operands; the counter models the fixed latency.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
`ifdef MUU_ACCUM_EN
  logic [63:0] prod_u, acc;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign acc    = {hi_q, lo_q};
`endif

  // One restoring step on magnitudes: shift quotient MSB into remainder,
  // subtract divisor if it fits.
  always_comb begin
    r2       = {rem_q, quo_q[31]};
    diff     = r2 - {1'b0, div_q};
    rem_step = diff[32] ? r2[31:0] : diff[31:0];
    quo_step = {quo_q[30:0], ~diff[32]};
  end

  // HI/LO commit values; also forwarded to MFHI/MFLO accepted on the commit edge.
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (mul_fin) begin
      case (op_q)
        OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
`ifdef MUU_ACCUM_EN
        OP_MADD:  {hi_nxt, lo_nxt} = acc + prod_s;
        OP_MSUBU: {hi_nxt, lo_nxt} = acc - prod_u;
`endif
        default: ;
      endcase
    end else if (div_fin) begin
      lo_nxt = (rs_neg_q ^ rt_neg_q) ? (32'd0 - quo_q) : quo_q;
      hi_nxt = rs_neg_q ? (32'd0 - rem_q) : rem_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 5'd0;
      op_q        <= '0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      div_q       <= 32'd0;
      rs_neg_q    <= 1'b0;
      rt_neg_q    <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      out_q       <= 32'd0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= hi_nxt;
      lo_q        <= lo_nxt;

      if (mul_out_live)
        out_q <= prod_s[31:0];

      if (state == DIVI) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
      end
      if (((state == DIVI) || (state == MULW)) && (cnt != 5'd0))
        cnt <= cnt - 5'd1;

      if (accept) begin
        op_q <= op;
        if (is_mulc) begin
          a_q <= rs;
          b_q <= rt;
          cnt <= 5'(MUL_LAT - 1);
        end else if (is_div) begin
          if (rt == 32'd0) begin
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end else begin
            rem_q    <= 32'd0;
            quo_q    <= rs[31] ? (32'd0 - rs) : rs;
            div_q    <= rt[31] ? (32'd0 - rt) : rt;
            rs_neg_q <= rs[31];
            rt_neg_q <= rt[31];
            cnt      <= 5'd31;
          end
        end else if (is_mf) begin
          // Takes priority over a MUL result committing on the same edge.
          out_q       <= (op == OP_MFHI) ? hi_nxt : lo_nxt;
          out_valid_q <= 1'b1;
          done_q      <= 1'b1;
        end else begin
          illegal_q <= 1'b1;
          done_q    <= 1'b1;
        end
      end
    end
  end

  // Completion pulses of multi-cycle ops are suppressed while reset aborts them.
  assign mul_out_live = mul_fin && (op_q == OP_MUL);
  assign done         = done_q | ((mul_fin | div_fin) & ~reset);
  assign out_valid    = out_valid_q | (mul_out_live & ~reset);
  assign out          = mul_out_live ? prod_s[31:0] : out_q;
  assign div_zero     = div_zero_q;
  assign illegal      = illegal_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_muu_sequencer.sv
// tb/tb_muu_sequencer.sv - directed self-checking bench for muu_sequencer
module tb_muu_sequencer;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        ready, busy, done, out_valid, div_zero, illegal;
  logic [31:0] out, hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  muu_sequencer #(.MUL_LAT(MUL_LAT), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .ready(ready), .busy(busy), .done(done), .out(out), .out_valid(out_valid),
    .div_zero(div_zero), .illegal(illegal), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request and return at the falling edge of the done cycle;
  // lat is the cycle index after the accept edge (100 means no done seen).
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o}); end
    n_checks++; if (out !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
  endtask

  task automatic test_mult;
    int lat;
    do_op(4'd1, 32'hFFFFFFFE, 32'd3, lat);
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult_latency: got %0d want %0d", lat, MUL_LAT); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    n_checks++; if (hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi_o); end
    n_checks++; if (lo_o !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo_o); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b want 0", done); end
  endtask

  task automatic test_mul;
    int lat;
    do_op(4'd0, 32'd7, 32'hFFFFFFFD, lat);
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_out: got %h want ffffffeb", out); end
    @(negedge clk);
    n_checks++; if (out !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_out_hold: got %h want ffffffeb", out); end
    n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFA) begin n_fail++; $display("FAIL mul_hilo_kept: got %h want fffffffffffffffa", {hi_o, lo_o}); end
  endtask

  task automatic test_accum;
    int lat;
    do_op(4'd1, 32'h0000FFFF, 32'h00010001, lat);
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL accum_setup: got %h want 00000000ffffffff", {hi_o, lo_o}); end
    do_op(4'd2, 32'd1, 32'd1, lat);
`ifdef MUU_ACCUM_EN
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL madd_latency: got %0d want %0d", lat, MUL_LAT); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000001_00000000) begin n_fail++; $display("FAIL madd_hilo: got %h want 0000000100000000", {hi_o, lo_o}); end
`else
    n_checks++; if (lat !== 1 || illegal !== 1'b1) begin n_fail++; $display("FAIL madd_illegal: got lat %0d illegal %b want lat 1 illegal 1", lat, illegal); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL madd_hilo_kept: got %h want 00000000ffffffff", {hi_o, lo_o}); end
`endif
    do_op(4'd1, 32'd0, 32'd0, lat);
    do_op(4'd3, 32'hFFFFFFFF, 32'd2, lat);
`ifdef MUU_ACCUM_EN
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000002) begin n_fail++; $display("FAIL msubu_hilo: got %h want fffffffe00000002", {hi_o, lo_o}); end
`else
    n_checks++; if (lat !== 1 || illegal !== 1'b1) begin n_fail++; $display("FAIL msubu_illegal: got lat %0d illegal %b want lat 1 illegal 1", lat, illegal); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL msubu_hilo_kept: got %h want 0", {hi_o, lo_o}); end
`endif
  endtask

  task automatic test_div;
    int lat;
    do_op(4'd4, 32'hFFFFFFF9, 32'd2, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_no_zero_flag: got %b want 0", div_zero); end
    @(negedge clk);
    n_checks++; if (lo_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo_o); end
    n_checks++; if (hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi_o); end
    do_op(4'd4, 32'd7, 32'hFFFFFFFE, lat);
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000001_FFFFFFFD) begin n_fail++; $display("FAIL div_negdivisor: got %h want 00000001fffffffd", {hi_o, lo_o}); end
    do_op(4'd4, 32'h80000000, 32'hFFFFFFFF, lat);
    n_checks++; if (div_zero !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL div_ovf_flags: got dz %b ill %b want 0 0", div_zero, illegal); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_ovf: got %h want 0000000080000000", {hi_o, lo_o}); end
  endtask

  task automatic test_div_zero_illegal;
    int lat;
    do_op(4'd4, 32'd5, 32'd0, lat);
    n_checks++; if (lat !== 1 || div_zero !== 1'b1) begin n_fail++; $display("FAIL divz_pulse: got lat %0d dz %b want lat 1 dz 1", lat, div_zero); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL divz_hilo_kept: got %h want 0000000080000000", {hi_o, lo_o}); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL divz_width: got %b want 0", div_zero); end
    do_op(4'hF, 32'd1, 32'd1, lat);
    n_checks++; if (lat !== 1 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill_pulse: got lat %0d ill %b want lat 1 ill 1", lat, illegal); end
    n_checks++; if (out_valid !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL ill_only: got ov %b dz %b want 0 0", out_valid, div_zero); end
    @(negedge clk);
    n_checks++; if ({hi_o, lo_o} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL ill_hilo_kept: got %h want 0000000080000000", {hi_o, lo_o}); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = 4'd1; rs = 32'd5; rt = 32'd6;
    @(posedge clk);
    @(negedge clk);
    op = 4'd6; rs = 32'hDEAD; rt = 32'hBEEF;
    cyc = 1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got ready %b want 0", ready); end
    while (ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc !== MUL_LAT || done !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_return: got cycle %0d done %b want cycle %0d done 1", cyc, done, MUL_LAT); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL b2b_mflo_pulse: got ov %b done %b want 1 1", out_valid, done); end
    n_checks++; if (out !== 32'd30) begin n_fail++; $display("FAIL b2b_mflo_out: got %0d want 30", out); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out !== 32'd30) begin n_fail++; $display("FAIL b2b_hold: got ov %b out %0d want 0 30", out_valid, out); end
  endtask

  task automatic test_reset_mid_div;
    int seen_done;
    @(negedge clk);
    start = 1'b1; op = 4'd4; rs = 32'd100; rt = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_div_ready: got %b want 1", ready); end
    n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL rst_div_hilo: got %h want 0", {hi_o, lo_o}); end
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL rst_div_no_done: got %0d done pulses want 0", seen_done); end
    n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL rst_div_hilo_after: got %h want 0", {hi_o, lo_o}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mul;
    test_accum;
    test_div;
    test_div_zero_illegal;
    test_back_to_back;
    test_reset_mid_div;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
